// File: rtl/multiphase_pwm.sv
// multiphase_pwm: N-channel phase-shifted complementary PWM generator.
// One master counter feeds every channel. Each channel has its own phase offset,
// double-buffered duty and a dead-time engine.
// Optional feature: define MULTIPHASE_PWM_FAULT_EN to add the latched fault
// shutdown ports (fault, fault_clr, fault_latched).
module multiphase_pwm #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DT_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [CHANNELS*WIDTH-1:0]    duty_in,
   input  logic                         duty_load,
   input  logic [DT_WIDTH-1:0]          dead_time,
`ifdef MULTIPHASE_PWM_FAULT_EN
   input  logic                         fault,
   input  logic                         fault_clr,
   output logic                         fault_latched,
`endif
   output logic                         period_start,
   output logic [CHANNELS-1:0]          pwm_hi,
   output logic [CHANNELS-1:0]          pwm_lo
);

   logic [WIDTH-1:0] ctr;
   logic             wrap;
   logic             force_off;

   // The last count of a running period: shadow duty moves to active here
   assign wrap = en && (ctr == '1);

   // Start-of-period marker, derived from the registered counter
   assign period_start = en && (ctr == '0);

   // Master counter: free-running modulo 2^WIDTH while enabled, holds otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr <= '0;
      end else if (en) begin
         ctr <= ctr + WIDTH'(1);
      end
   end

`ifdef MULTIPHASE_PWM_FAULT_EN
   // Fault latch: set by fault, cleared by fault_clr only once fault has gone away
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_latched <= 1'b0;
      end else if (fault) begin
         fault_latched <= 1'b1;
      end else if (fault_clr) begin
         fault_latched <= 1'b0;
      end
   end

   // A live fault blanks outputs at the same edge it is latched
   assign force_off = !en || fault || fault_latched;
`else
   assign force_off = !en;
`endif

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      // Evenly spaced phase offset, fixed at elaboration
      localparam longint unsigned OFF_L = (longint'(k) << WIDTH) / longint'(CHANNELS);
      localparam logic [WIDTH-1:0] OFF  = WIDTH'(OFF_L);

      logic [WIDTH-1:0]    shadow;
      logic [WIDTH-1:0]    act_duty;
      logic [WIDTH-1:0]    pc;
      logic                raw;
      logic                raw_q;
      logic [DT_WIDTH-1:0] timer;
      logic                hi_q;
      logic                lo_q;

      assign pc  = ctr + OFF;
      assign raw = pc < act_duty;

      // Duty double buffer; a load on the wrap cycle goes straight to active
      always_ff @(posedge clk) begin
         if (rst) begin
            shadow   <= '0;
            act_duty <= '0;
         end else begin
            if (duty_load) begin
               shadow <= duty_in[k*WIDTH +: WIDTH];
            end
            if (wrap) begin
               act_duty <= duty_load ? duty_in[k*WIDTH +: WIDTH] : shadow;
            end
         end
      end

      // Dead-time engine: any raw change or shutdown blanks both sides and
      // reloads the timer; the demanded side is driven once the timer expires
      always_ff @(posedge clk) begin
         if (rst) begin
            raw_q <= 1'b0;
            timer <= '0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
         end else begin
            raw_q <= raw;
            if (force_off) begin
               timer <= dead_time;
               hi_q  <= 1'b0;
               lo_q  <= 1'b0;
            end else if (raw != raw_q) begin
               timer <= dead_time;
               hi_q  <= raw && (dead_time == '0);
               lo_q  <= !raw && (dead_time == '0);
            end else if (timer > DT_WIDTH'(1)) begin
               timer <= timer - DT_WIDTH'(1);
               hi_q  <= 1'b0;
               lo_q  <= 1'b0;
            end else begin
               timer <= '0;
               hi_q  <= raw;
               lo_q  <= !raw;
            end
         end
      end

      assign pwm_hi[k] = hi_q;
      assign pwm_lo[k] = lo_q;
   end

endmodule
